// File: rtl/intc_pkg.sv
// Shared register map, bank codes and helpers for the priority interrupt controller.
package intc_pkg;

  localparam logic [1:0] ADDR_CMD    = 2'd0;
  localparam logic [1:0] ADDR_DATA   = 2'd1;
  localparam logic [1:0] ADDR_VECTOR = 2'd2;
  localparam logic [1:0] ADDR_EOI    = 2'd3;

  localparam logic [3:0] BANK_EN   = 4'h1;
  localparam logic [3:0] BANK_TYPE = 4'h2;
  localparam logic [3:0] BANK_PEND = 4'h3;
  localparam logic [3:0] BANK_ISR  = 4'h4;
  localparam logic [3:0] BANK_SEL  = 4'h8;
  localparam logic [3:0] BANK_PRIO = 4'h9;

  localparam logic [7:0] NO_IRQ = 8'hFF;

  localparam logic TYPE_EDGE  = 1'b0;
  localparam logic TYPE_LEVEL = 1'b1;

  // Byte idx of a source vector that has been zero-extended to 256 bits.
  function automatic logic [7:0] pick_byte(input logic [255:0] vec, input logic [3:0] idx);
    return vec[{1'b0, idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/prio_resolver.sv
// Picks the highest-priority requester; on equal priority the lowest index wins.
module prio_resolver #(
  parameter int N      = 64,
  parameter int PRIO_W = 3
) (
  input  logic [N-1:0]        req_i,
  input  logic [N*PRIO_W-1:0] prio_i,
  output logic                valid_o,
  output logic [7:0]          idx_o,
  output logic [PRIO_W-1:0]   prio_o
);

  logic              found_c;
  logic [7:0]        idx_c;
  logic [PRIO_W-1:0] best_c;

  // Strict greater-than keeps the earlier (lower) index on ties.
  always_comb begin
    found_c = 1'b0;
    idx_c   = '0;
    best_c  = '0;
    for (int i = 0; i < N; i++) begin
      if (req_i[i] && (!found_c || (prio_i[i*PRIO_W +: PRIO_W] > best_c))) begin
        found_c = 1'b1;
        idx_c   = 8'(i);
        best_c  = prio_i[i*PRIO_W +: PRIO_W];
      end
    end
  end

  assign valid_o = found_c;
  assign idx_o   = idx_c;
  assign prio_o  = best_c;

endmodule

// File: rtl/prio_interrupt_controller.sv
// Priority interrupt controller: edge/level sources, nested in-service tracking,
// vector read-acknowledge and EOI, single registered IRQ line to the CPU.
module prio_interrupt_controller
  import intc_pkg::*;
#(
  parameter int NUM_IRQ = 64,
  parameter int PRIO_W  = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [7:0]         i_data,
  output logic [7:0]         o_data,
  input  logic [1:0]         addr,
  input  logic               cs,
  input  logic               rwb,
  input  logic [NUM_IRQ-1:0] int_in,
  output logic               int_out
);

  localparam logic [8:0] NUM_IRQ_W = 9'(NUM_IRQ);

  logic [NUM_IRQ-1:0] en_q, en_d;
  logic [NUM_IRQ-1:0] type_q, type_d;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] isr_q, isr_d;
  logic [NUM_IRQ-1:0] prev_q;
  logic [7:0]         sel_q, sel_d;
  logic [7:0]         cmd_q, cmd_d;
  logic [PRIO_W-1:0]  prio_q [NUM_IRQ];
  logic [PRIO_W-1:0]  prio_d [NUM_IRQ];
  logic               irq_q, irq_d;

  logic               we, re;
  logic               cmd_wr, data_wr, vec_rd, eoi_wr, vec_ack;
  logic [3:0]         bank;
  logic [NUM_IRQ-1:0] byte_hit, byte_wdata;
  logic [NUM_IRQ-1:0] w1c_mask, ack_mask, eoi_mask;
  logic [NUM_IRQ-1:0] rise, edge_pend;
  logic [NUM_IRQ*PRIO_W-1:0] prio_flat;

  logic               best_valid, cur_valid;
  logic [7:0]         best_idx, cur_idx;
  logic [PRIO_W-1:0]  best_prio, cur_prio;
  logic [PRIO_W-1:0]  sel_prio;
  logic [7:0]         data_rd, rd_mux;

  assign we      = cs & ~rwb;
  assign re      = cs & rwb;
  assign cmd_wr  = we && (addr == ADDR_CMD);
  assign data_wr = we && (addr == ADDR_DATA);
  assign eoi_wr  = we && (addr == ADDR_EOI);
  assign vec_rd  = re && (addr == ADDR_VECTOR);
  assign vec_ack = vec_rd && irq_q;
  assign bank    = cmd_q[7:4];
  assign rise    = int_in & ~prev_q;

  prio_resolver #(.N(NUM_IRQ), .PRIO_W(PRIO_W)) u_best (
    .req_i   (pend_q & ~isr_q),
    .prio_i  (prio_flat),
    .valid_o (best_valid),
    .idx_o   (best_idx),
    .prio_o  (best_prio)
  );

  prio_resolver #(.N(NUM_IRQ), .PRIO_W(PRIO_W)) u_cur (
    .req_i   (isr_q),
    .prio_i  (prio_flat),
    .valid_o (cur_valid),
    .idx_o   (cur_idx),
    .prio_o  (cur_prio)
  );

  // Bits outside the implemented range never match a byte index, so they read 0.
  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_src
    localparam logic [4:0] BYTE_IDX = 5'(g / 8);
    assign byte_hit[g]   = ({1'b0, cmd_q[3:0]} == BYTE_IDX);
    assign byte_wdata[g] = i_data[g % 8];
    assign prio_flat[g*PRIO_W +: PRIO_W] = prio_q[g];
    assign pend_d[g] = en_d[g] & (((type_d[g] == TYPE_LEVEL) & int_in[g]) |
                                  ((type_d[g] == TYPE_EDGE)  & edge_pend[g]));
  end

  always_comb begin
    cmd_d    = cmd_q;
    sel_d    = sel_q;
    en_d     = en_q;
    type_d   = type_q;
    prio_d   = prio_q;
    w1c_mask = '0;
    if (cmd_wr) cmd_d = i_data;
    if (data_wr) begin
      unique case (bank)
        BANK_EN:   en_d     = (en_q & ~byte_hit) | (byte_wdata & byte_hit);
        BANK_TYPE: type_d   = (type_q & ~byte_hit) | (byte_wdata & byte_hit);
        BANK_PEND: w1c_mask = byte_wdata & byte_hit;
        BANK_SEL:  if ({1'b0, i_data} < NUM_IRQ_W) sel_d = i_data;
        BANK_PRIO: begin
          for (int i = 0; i < NUM_IRQ; i++) begin
            if (sel_q == 8'(i)) prio_d[i] = i_data[PRIO_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ack_mask = '0;
    eoi_mask = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      ack_mask[i] = vec_ack && (best_idx == 8'(i));
      eoi_mask[i] = eoi_wr && cur_valid && (cur_idx == 8'(i));
    end
  end

  // A fresh edge in the same cycle as an ack or W1C wins, so the source stays pending.
  assign edge_pend = (pend_q & ~(w1c_mask | ack_mask)) | rise;
  assign isr_d     = (isr_q | ack_mask) & ~eoi_mask;
  assign irq_d     = best_valid && (!cur_valid || (best_prio > cur_prio));

  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_q   <= '0;
      type_q <= '0;
      pend_q <= '0;
      isr_q  <= '0;
      prev_q <= '0;
      sel_q  <= '0;
      cmd_q  <= '0;
      prio_q <= '{default: '0};
      irq_q  <= 1'b0;
    end else begin
      en_q   <= en_d;
      type_q <= type_d;
      pend_q <= pend_d;
      isr_q  <= isr_d;
      prev_q <= int_in;
      sel_q  <= sel_d;
      cmd_q  <= cmd_d;
      prio_q <= prio_d;
      irq_q  <= irq_d;
    end
  end

  always_comb begin
    sel_prio = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (sel_q == 8'(i)) sel_prio = prio_q[i];
    end
  end

  always_comb begin
    data_rd = '0;
    unique case (bank)
      BANK_EN:   data_rd = pick_byte(256'(en_q),   cmd_q[3:0]);
      BANK_TYPE: data_rd = pick_byte(256'(type_q), cmd_q[3:0]);
      BANK_PEND: data_rd = pick_byte(256'(pend_q), cmd_q[3:0]);
      BANK_ISR:  data_rd = pick_byte(256'(isr_q),  cmd_q[3:0]);
      BANK_SEL:  data_rd = sel_q;
      BANK_PRIO: data_rd = 8'(sel_prio);
      default:   data_rd = '0;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    unique case (addr)
      ADDR_CMD:    rd_mux = cmd_q;
      ADDR_DATA:   rd_mux = data_rd;
      ADDR_VECTOR: rd_mux = irq_q ? best_idx : NO_IRQ;
      default:     rd_mux = '0;
    endcase
  end

  assign o_data  = (re && reset_n) ? rd_mux : 8'h00;
  assign int_out = irq_q;

endmodule
